pdm_port_rx: RTL and testbench

- Synthesizable receiver for one PDM output port. It is the far end of the newdata_len / proceed / data_out handshake that the core drives on each of its four output ports.
- Accepts a length announcement and grants it with a one-cycle proceed pulse once buffer space is available.
- Captures the announced bytes into an internal packet FIFO and presents them downstream on a valid/ready byte stream with start-of-packet and end-of-packet markers.
- One instance is placed per output port (four per PDM).

---
 rtl/pdm_rx_pkg.sv | 21 ++
 rtl/pdm_rx_fifo.sv | 59 +++++
 rtl/pdm_port_rx.sv | 151 +++++++++++++++
 tb/tb_pdm_port_rx.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pdm_rx_pkg.sv
// Shared types and defaults for the PDM output-port receiver.
package pdm_rx_pkg;

    localparam int LEN_W  = 5;
    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_SPACE = 3'd1,
        GRANT      = 3'd2,
        GAP        = 3'd3,
        RECV       = 3'd4
    } state_t;

    typedef struct packed {
        logic              sop;
        logic              eop;
        logic [BYTE_W-1:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/pdm_rx_fifo.sv
// First-word-fall-through packet FIFO: the head entry is visible combinationally
// from registered storage; pointers wrap naturally because DEPTH is a power of two.
module pdm_rx_fifo
    import pdm_rx_pkg::*;
#(
    parameter int  DEPTH   = 32,
    parameter type entry_t = fifo_entry_t
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  entry_t                 wr_entry,
    input  logic                   rd_en,
    output entry_t                 rd_entry,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    entry_t        mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;

    // Storage array; contents are only observed when the FIFO is non-empty
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_ptr_r] <= wr_entry;
        end
    end

    // Pointer and occupancy tracking; a simultaneous write and read keeps count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (wr_en) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (rd_en) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign rd_entry = mem_r[rd_ptr_r];
    assign empty    = (count_r == {CW{1'b0}});
    assign count    = count_r;

endmodule

// File: rtl/pdm_port_rx.sv
// Receiver for one PDM output port: grants length announcements when space is
// available, buffers the packet bytes and streams them out with sop/eop markers.
module pdm_port_rx #(
    parameter int FIFO_DEPTH = 32,
    parameter int LEN_W      = 5,
    parameter int BYTE_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [LEN_W-1:0]  newdata_len,
    output logic              proceed,
    input  logic [BYTE_W-1:0] data_out,
    output logic [BYTE_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic              rd_sop,
    output logic              rd_eop,
    output logic [7:0]        pkt_count,
    output logic              proto_err,
    input  logic              err_clr
);

    import pdm_rx_pkg::*;

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    typedef struct packed {
        logic              sop;
        logic              eop;
        logic [BYTE_W-1:0] data;
    } entry_t;

    state_t           state_r;
    logic [LEN_W-1:0] len_r;
    logic [LEN_W-1:0] byte_cnt_r;
    logic             proceed_r;
    logic [7:0]       pkt_count_r;
    logic             proto_err_r;

    logic             ann_s;
    logic             oversize_s;
    logic             space_ok_s;
    logic             err_set_s;
    logic             wr_en_s;
    logic             rd_en_s;
    logic             empty_s;
    logic [CW-1:0]    count_s;
    logic [CW-1:0]    free_s;
    entry_t           wr_entry_s;
    entry_t           rd_entry_s;

    assign ann_s      = |newdata_len;
    assign oversize_s = (32'(newdata_len) > 32'(FIFO_DEPTH));
    assign free_s     = CW'(FIFO_DEPTH) - count_s;
    // Reads only ever add space, so checking once at grant time is enough
    assign space_ok_s = (32'(len_r) <= 32'(free_s));
    assign err_set_s  = ann_s && ((state_r != IDLE) || oversize_s);

    assign wr_en_s         = (state_r == RECV);
    assign wr_entry_s.sop  = (byte_cnt_r == len_r);
    assign wr_entry_s.eop  = (byte_cnt_r == LEN_W'(1));
    assign wr_entry_s.data = data_out;
    assign rd_en_s         = rd_ready && !empty_s;

    pdm_rx_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en_s),
        .wr_entry (wr_entry_s),
        .rd_en    (rd_en_s),
        .rd_entry (rd_entry_s),
        .empty    (empty_s),
        .count    (count_s)
    );

    // Handshake FSM: announce -> wait for space -> grant pulse -> gap -> capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            len_r       <= {LEN_W{1'b0}};
            byte_cnt_r  <= {LEN_W{1'b0}};
            proceed_r   <= 1'b0;
            pkt_count_r <= 8'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (ann_s && !oversize_s) begin
                        len_r   <= newdata_len;
                        state_r <= WAIT_SPACE;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                WAIT_SPACE: begin
                    if (space_ok_s) begin
                        proceed_r <= 1'b1;
                        state_r   <= GRANT;
                    end else begin
                        state_r <= WAIT_SPACE;
                    end
                end
                GRANT: begin
                    proceed_r <= 1'b0;
                    state_r   <= GAP;
                end
                GAP: begin
                    byte_cnt_r <= len_r;
                    state_r    <= RECV;
                end
                RECV: begin
                    byte_cnt_r <= byte_cnt_r - LEN_W'(1);
                    if (byte_cnt_r == LEN_W'(1)) begin
                        pkt_count_r <= pkt_count_r + 8'd1;
                        state_r     <= IDLE;
                    end else begin
                        state_r <= RECV;
                    end
                end
                default: begin
                    proceed_r <= 1'b0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

    // Sticky protocol error; a newly detected error beats a clear request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            proto_err_r <= 1'b0;
        end else if (err_set_s) begin
            proto_err_r <= 1'b1;
        end else if (err_clr) begin
            proto_err_r <= 1'b0;
        end else begin
            proto_err_r <= proto_err_r;
        end
    end

    assign proceed   = proceed_r;
    assign pkt_count = pkt_count_r;
    assign proto_err = proto_err_r;
    assign rd_valid  = !empty_s;
    assign rd_data   = empty_s ? {BYTE_W{1'b0}} : rd_entry_s.data;
    assign rd_sop    = !empty_s && rd_entry_s.sop;
    assign rd_eop    = !empty_s && rd_entry_s.eop;

endmodule

// File: tb/tb_pdm_port_rx.sv
// Scoreboard bench for pdm_port_rx: a 32-deep instance (a_*) and an 8-deep instance (b_*).
module tb_pdm_port_rx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       a_rst, b_rst;
    logic [4:0] a_len, b_len;
    logic [7:0] a_din, b_din;
    logic       a_rd_ready, b_rd_ready, a_err_clr, b_err_clr;
    logic       a_proceed, b_proceed, a_rd_valid, b_rd_valid;
    logic       a_rd_sop, b_rd_sop, a_rd_eop, b_rd_eop;
    logic [7:0] a_rd_data, b_rd_data, a_pkt_count, b_pkt_count;
    logic       a_proto_err, b_proto_err;
    logic       stress_on = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;
    logic [9:0] exp_a[$];
    logic [9:0] exp_b[$];

    pdm_port_rx #(.FIFO_DEPTH(32), .LEN_W(5), .BYTE_W(8)) u_dut_a (
        .clk(clk), .rst(a_rst), .newdata_len(a_len), .proceed(a_proceed),
        .data_out(a_din), .rd_data(a_rd_data), .rd_valid(a_rd_valid),
        .rd_ready(a_rd_ready), .rd_sop(a_rd_sop), .rd_eop(a_rd_eop),
        .pkt_count(a_pkt_count), .proto_err(a_proto_err), .err_clr(a_err_clr)
    );

    pdm_port_rx #(.FIFO_DEPTH(8), .LEN_W(5), .BYTE_W(8)) u_dut_b (
        .clk(clk), .rst(b_rst), .newdata_len(b_len), .proceed(b_proceed),
        .data_out(b_din), .rd_data(b_rd_data), .rd_valid(b_rd_valid),
        .rd_ready(b_rd_ready), .rd_sop(b_rd_sop), .rd_eop(b_rd_eop),
        .pkt_count(b_pkt_count), .proto_err(b_proto_err), .err_clr(b_err_clr)
    );

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
        end
    endtask

    function automatic string pfx(input bit sel);
        return sel ? "b_" : "a_";
    endfunction

    function automatic logic get_proceed(input bit sel);
        return sel ? b_proceed : a_proceed;
    endfunction

    task automatic drive_len(input bit sel, input logic [4:0] v);
        if (sel) b_len = v; else a_len = v;
    endtask

    task automatic drive_din(input bit sel, input logic [7:0] v);
        if (sel) b_din = v; else a_din = v;
    endtask

    task automatic push(input bit sel, input logic [9:0] e);
        if (sel) exp_b.push_back(e); else exp_a.push_back(e);
    endtask

    // Monitors: pop the expected entry on every accepted downstream transfer
    always @(negedge clk) begin
        if (a_rd_valid && a_rd_ready) begin
            if (exp_a.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL a_extra_byte: got 0x%0h, none expected", {a_rd_sop, a_rd_eop, a_rd_data});
            end else begin
                check("a_stream", {22'd0, a_rd_sop, a_rd_eop, a_rd_data}, {22'd0, exp_a.pop_front()});
            end
        end
        if (b_rd_valid && b_rd_ready) begin
            if (exp_b.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL b_extra_byte: got 0x%0h, none expected", {b_rd_sop, b_rd_eop, b_rd_data});
            end else begin
                check("b_stream", {22'd0, b_rd_sop, b_rd_eop, b_rd_data}, {22'd0, exp_b.pop_front()});
            end
        end
    end

    initial forever begin
        @(posedge clk); #1;
        if (stress_on) a_rd_ready = 1'($urandom_range(0, 1));
    end

    task automatic announce(input bit sel, input logic [4:0] len);
        drive_len(sel, len);
        @(posedge clk); #1;
        drive_len(sel, 5'd0);
    endtask

    task automatic wait_grant(input bit sel, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            if (get_proceed(sel)) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!ok) begin
            n_cmp++; n_bad++;
            $display("FAIL %sgrant_timeout: proceed stayed 0 for 2000 cycles, required 1", pfx(sel));
        end
    endtask

    // Core model, entered in the GRANT cycle: one gap cycle, then one byte per cycle.
    // inj=1 announces len 2 while busy; inj=2 resets instance a during byte 2.
    task automatic send_bytes(input bit sel, input int len, input logic [7:0] base,
                              input int step, input int inj);
        logic [7:0] d;
        @(posedge clk); #1;
        check({pfx(sel), "proceed_gap"}, 32'(get_proceed(sel)), 32'd0);
        @(posedge clk); #1;
        for (int i = 0; i < len; i++) begin
            d = base + 8'(i * step);
            drive_din(sel, d);
            if (inj == 2 && i == 1) begin
                a_rst = 1'b1;
                #1;
                check("rst_proceed", 32'(a_proceed), 32'd0);
                check("rst_rd_valid", 32'(a_rd_valid), 32'd0);
                check("rst_pkt_count", 32'(a_pkt_count), 32'd0);
                exp_a.delete();
                @(posedge clk); #1;
                a_rst = 1'b0;
                a_din = 8'd0;
                return;
            end
            push(sel, {(i == 0), (i == len - 1), d});
            if (inj == 1 && i == 2) drive_len(sel, 5'd2);
            @(posedge clk); #1;
            drive_len(sel, 5'd0);
        end
        drive_din(sel, 8'd0);
    endtask

    task automatic send_pkt(input bit sel, input int len, input logic [7:0] base,
                            input int step, input int inj);
        bit ok;
        announce(sel, 5'(len));
        wait_grant(sel, ok);
        if (ok) send_bytes(sel, len, base, step, inj);
    endtask

    task automatic wait_drain(input bit sel);
        int left;
        for (int k = 0; k < 3000; k++) begin
            left = sel ? exp_b.size() : exp_a.size();
            if (left == 0 && !(sel ? b_rd_valid : a_rd_valid)) break;
            @(posedge clk); #1;
        end
        left = sel ? exp_b.size() : exp_a.size();
        check({pfx(sel), "drain_left"}, 32'(left), 32'd0);
    endtask

    initial begin
        bit ok;
        bit seen;
        a_rst = 1'b1; b_rst = 1'b1;
        a_len = 5'd0; b_len = 5'd0; a_din = 8'd0; b_din = 8'd0;
        a_rd_ready = 1'b0; b_rd_ready = 1'b0; a_err_clr = 1'b0; b_err_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_a_proceed", 32'(a_proceed), 32'd0);
        check("rst_a_rd_valid", 32'(a_rd_valid), 32'd0);
        check("rst_a_sop_eop", {30'd0, a_rd_sop, a_rd_eop}, 32'd0);
        check("rst_a_rd_data", 32'(a_rd_data), 32'd0);
        check("rst_a_pkt_count", 32'(a_pkt_count), 32'd0);
        check("rst_a_proto_err", 32'(a_proto_err), 32'd0);
        check("rst_b_proto_err", 32'(b_proto_err), 32'd0);
        a_rst = 1'b0; b_rst = 1'b0;
        @(posedge clk); #1;

        // Single packet A1,A2,A3 with exact proceed timing
        a_rd_ready = 1'b1;
        announce(1'b0, 5'd3);
        check("a_proceed_wait", 32'(a_proceed), 32'd0);
        @(posedge clk); #1;
        check("a_proceed_grant", 32'(a_proceed), 32'd1);
        send_bytes(1'b0, 3, 8'hA1, 1, 0);
        wait_drain(1'b0);
        check("a_pkt_count_single", 32'(a_pkt_count), 32'd1);

        // Announcement while busy: flagged, packet still intact
        send_pkt(1'b0, 6, 8'h10, 3, 1);
        check("a_busy_err", 32'(a_proto_err), 32'd1);
        wait_drain(1'b0);
        check("a_pkt_count_busy", 32'(a_pkt_count), 32'd2);
        check("a_err_sticky", 32'(a_proto_err), 32'd1);
        a_err_clr = 1'b1;
        @(posedge clk); #1;
        a_err_clr = 1'b0;
        check("a_err_clr", 32'(a_proto_err), 32'd0);

        // Reset during byte 2 of a 4-byte packet, then a clean 1-byte packet
        a_rd_ready = 1'b0;
        send_pkt(1'b0, 4, 8'hC0, 1, 2);
        a_rd_ready = 1'b1;
        send_pkt(1'b0, 1, 8'h55, 1, 0);
        wait_drain(1'b0);
        check("a_pkt_count_after_rst", 32'(a_pkt_count), 32'd1);

        // Backpressure on the 8-deep instance
        send_pkt(1'b1, 5, 8'h60, 1, 0);
        announce(1'b1, 5'd4);
        seen = 1'b0;
        repeat (10) begin
            if (b_proceed) seen = 1'b1;
            @(posedge clk); #1;
        end
        check("b_hold_no_grant", 32'(seen), 32'd0);
        check("b_head_sop", {30'd0, b_rd_valid, b_rd_sop}, 32'd3);
        b_rd_ready = 1'b1;
        wait_grant(1'b1, ok);
        if (ok) send_bytes(1'b1, 4, 8'h70, 1, 0);
        wait_drain(1'b1);
        check("b_pkt_count_bp", 32'(b_pkt_count), 32'd2);

        // Oversize announcement: flagged, dropped, FSM still idle
        announce(1'b1, 5'd20);
        check("b_oversize_err", 32'(b_proto_err), 32'd1);
        seen = 1'b0;
        repeat (5) begin
            if (b_proceed) seen = 1'b1;
            @(posedge clk); #1;
        end
        check("b_oversize_no_grant", 32'(seen), 32'd0);
        send_pkt(1'b1, 2, 8'h90, 1, 0);
        wait_drain(1'b1);
        check("b_pkt_count_after_oversize", 32'(b_pkt_count), 32'd3);

        // Stress: 300 random packets with random downstream ready
        a_rst = 1'b1;
        @(posedge clk); #1;
        a_rst = 1'b0;
        stress_on = 1'b1;
        for (int p = 0; p < 300; p++) begin
            send_pkt(1'b0, int'($urandom_range(1, 31)), 8'($urandom), int'($urandom_range(1, 255)), 0);
        end
        stress_on = 1'b0;
        @(posedge clk); #2;
        a_rd_ready = 1'b1;
        wait_drain(1'b0);
        check("a_pkt_count_stress", 32'(a_pkt_count), 32'd44);
        check("a_stress_err", 32'(a_proto_err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog");
    end

endmodule
